bp_update_sched: RTL and testbench
==================================

Name: bp_update_sched

Overview:
- Schedules all writes into the branch-predictor tables (meta, global, local) through one shared single-port table write channel.
- Buffers resolved-branch updates from execute in a small FIFO and drains them only in cycles when the frontend is not reading the tables.
- Runs a multi-cycle clear sweep after reset and after every predictor flush.
- Sits between execute/controller and the predictor tables; tables consume wr_* and gate predictions with busy_o.

Parameters:
- VLEN, 64, virtual PC width.
- NR_ENTRIES, 256, table entries; power of two, >=2.
- INDEX_LSB, 1, lowest PC bit used for the index (compressed-instruction granularity).
- FIFO_DEPTH, 4, update FIFO entries; power of two, >=2.
- CNT_W, 16, width of the dropped-update counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- flush_bp_i  in  1  predictor flush request.
- debug_mode_i  in  1  CPU in debug mode; updates are ignored.
- upd_valid_i  in  1  resolved branch update, fire-and-forget (execute never stalls).
- upd_pc_i  in  VLEN  PC of the resolved branch.
- upd_taken_i  in  1  resolved direction.
- upd_ready_o  out  1  FIFO can accept an update this cycle (informational only).
- rd_req_i  in  1  frontend reads the tables this cycle.
- wr_valid_o  out  1  table write this cycle.
- wr_clear_o  out  1  write is a clear to the reset state; wr_taken_o is don't-care.
- wr_index_o  out  log2(NR_ENTRIES)  table index.
- wr_pc_o  out  VLEN  PC for the update write (history/tag use); 0 on clear.
- wr_taken_o  out  1  direction for the update write.
- busy_o  out  1  clear sweep in progress; predictions invalid.
- drop_cnt_o  out  CNT_W  saturating count of updates lost to a full FIFO.

Behaviour:
- FSM states: CLEAR and RUN. State, sweep index clr_idx, FIFO pointers/count and drop_cnt are registers.
- Reset (rst_i high at an edge): state=CLEAR, clr_idx=0, FIFO empty, drop_cnt=0.
- Output values after reset: wr_valid_o=1, wr_clear_o=1, wr_index_o=0, wr_pc_o=0, wr_taken_o=0, busy_o=1, upd_ready_o=0, drop_cnt_o=0.
- Holding rst_i high for multiple cycles keeps all state at its reset value.
- CLEAR state:
  - Every cycle: wr_valid_o=1, wr_clear_o=1, wr_index_o=clr_idx. A clear write takes priority over rd_req_i.
  - clr_idx increments each cycle. After index NR_ENTRIES-1 is written, the next state is RUN.
  - A sweep takes exactly NR_ENTRIES cycles.
  - busy_o=1 and upd_ready_o=0. Updates arriving in CLEAR are discarded and not counted.
- RUN state:
  - busy_o=0.
  - If the FIFO is non-empty and rd_req_i=0: drive the FIFO head with wr_valid_o=1, wr_clear_o=0, wr_index_o = head.pc[INDEX_LSB +: log2(NR_ENTRIES)], wr_pc_o=head.pc, wr_taken_o=head.taken, and pop the head.
  - Otherwise wr_valid_o=0 and the other wr_* outputs are don't-care.
  - Push condition: upd_valid_i & !debug_mode_i & !flush_bp_i & (count<FIFO_DEPTH | pop this cycle).
  - upd_ready_o = (count<FIFO_DEPTH) | pop this cycle.
  - Push and pop in the same cycle: count is unchanged and the FIFO order is preserved.
  - Latency: an update accepted in cycle N appears on wr_* no earlier than cycle N+1. An update is never written in the cycle it arrives (no bypass).
  - Update rejected because the FIFO is full (all other push terms true): it is dropped and drop_cnt increments, saturating at 2^CNT_W-1.
- flush_bp_i (any state):
  - Next cycle: state=CLEAR, clr_idx=0, FIFO emptied.
  - A flush during CLEAR restarts the sweep at 0.
  - A same-cycle pop still happens.
  - A same-cycle update is dropped and not counted.
- drop_cnt is cleared only by reset; flushes do not clear it.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Updates are never reordered and never written twice.

Test Plan:
- Reset with rst_i high for 3 cycles, then release -> wr_clear_o=1 with wr_index_o 0,1,…,255 over 256 consecutive cycles; busy_o falls in the next cycle; drop_cnt_o=0.
- RUN, rd_req_i=0, one update pc=0x80000010 taken=1 in cycle N -> cycle N+1: wr_valid_o=1, wr_index_o=0x08, wr_taken_o=1, wr_clear_o=0.
- RUN, rd_req_i=1 held, 6 back-to-back updates -> first 4 accepted, upd_ready_o=0 after the 4th, drop_cnt_o=2; release rd_req_i -> 4 writes in FIFO order on consecutive cycles.
- FIFO full, rd_req_i=0, update arrives while head pops -> accepted, count stays 4, drop_cnt_o unchanged.
- flush_bp_i at sweep index 100 with the FIFO holding 2 updates -> next cycle wr_index_o=0; the 2 queued updates are never written; the sweep completes 256 cycles after the flush.
- debug_mode_i=1 with 3 updates -> no wr_valid_o, drop_cnt_o unchanged; an update concurrent with flush_bp_i is neither written nor counted.

Source files
------------

// File: rtl/bp_update_sched.sv
// Branch-predictor table write scheduler: buffers resolved-branch updates
// and sweeps the tables clear after reset or flush.
module bp_update_sched #(
    parameter int VLEN       = 64,
    parameter int NR_ENTRIES = 256,
    parameter int INDEX_LSB  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_bp_i,
    input  logic                          debug_mode_i,
    input  logic                          upd_valid_i,
    input  logic [VLEN-1:0]               upd_pc_i,
    input  logic                          upd_taken_i,
    output logic                          upd_ready_o,
    input  logic                          rd_req_i,
    output logic                          wr_valid_o,
    output logic                          wr_clear_o,
    output logic [$clog2(NR_ENTRIES)-1:0] wr_index_o,
    output logic [VLEN-1:0]               wr_pc_o,
    output logic                          wr_taken_o,
    output logic                          busy_o,
    output logic [CNT_W-1:0]              drop_cnt_o
);

    localparam int IW = $clog2(NR_ENTRIES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NR_ENTRIES - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     clr_idx;
    logic [VLEN-1:0]   fifo_pc    [FIFO_DEPTH];
    logic              fifo_taken [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CNT_W-1:0]  drop_cnt;
    logic              ready;
    logic              pop;
    logic              push;
    logic              drop;

    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        pop         = 1'b0;
        push        = 1'b0;
        drop        = 1'b0;
        wr_valid_o  = 1'b0;
        wr_clear_o  = 1'b0;
        wr_index_o  = fifo_pc[rd_ptr][INDEX_LSB +: IW];
        wr_pc_o     = fifo_pc[rd_ptr];
        wr_taken_o  = fifo_taken[rd_ptr];
        busy_o      = 1'b0;
        unique case (state)
            CLEAR: begin
                wr_valid_o = 1'b1;
                wr_clear_o = 1'b1;
                wr_index_o = clr_idx;
                wr_pc_o    = '0;
                wr_taken_o = 1'b0;
                busy_o     = 1'b1;
                if (clr_idx == LAST_IDX) state_nxt = RUN;
            end
            RUN: begin
                // Table reads from the frontend always win over queued updates
                pop        = (count != '0) && !rd_req_i;
                wr_valid_o = pop;
                ready      = (count < DEPTH_C) || pop;
                if (upd_valid_i && !debug_mode_i && !flush_bp_i) begin
                    push = ready;
                    drop = !ready;
                end
            end
            default: state_nxt = CLEAR;
        endcase
        if (flush_bp_i) state_nxt = CLEAR;
    end

    assign upd_ready_o = ready;
    assign drop_cnt_o  = drop_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= CLEAR;
            clr_idx  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (flush_bp_i) begin
                clr_idx <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
            end else begin
                if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= upd_pc_i;
            fifo_taken[wr_ptr] <= upd_taken_i;
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// Testbench for bp_update_sched: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_bp_update_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        dbg;
    logic        uv;
    logic [63:0] upc;
    logic        utk;
    logic        uready;
    logic        rd;
    logic        wv;
    logic        wclr;
    logic [7:0]  widx;
    logic [63:0] wpc;
    logic        wtk;
    logic        busy;
    logic [15:0] dcnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit          m_clearing;
    int          m_sweep;
    logic [64:0] m_q[$];
    int          m_drop;

    always #5 clk = ~clk;

    bp_update_sched dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_bp_i  (flush),
        .debug_mode_i(dbg),
        .upd_valid_i (uv),
        .upd_pc_i    (upc),
        .upd_taken_i (utk),
        .upd_ready_o (uready),
        .rd_req_i    (rd),
        .wr_valid_o  (wv),
        .wr_clear_o  (wclr),
        .wr_index_o  (widx),
        .wr_pc_o     (wpc),
        .wr_taken_o  (wtk),
        .busy_o      (busy),
        .drop_cnt_o  (dcnt)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare outputs with the model, then advance the model and the clock.
    task automatic step(input bit r, input bit f, input bit d, input bit v,
                        input logic [63:0] pc, input bit tk, input bit rq);
        bit pop;
        @(negedge clk);
        rst = r; flush = f; dbg = d; uv = v; upc = pc; utk = tk; rd = rq;
        #1;
        if (m_clearing) begin
            check("clr_valid", 64'(wv), 64'd1);
            check("clr_flag", 64'(wclr), 64'd1);
            check("clr_index", 64'(widx), 64'(m_sweep));
            check("clr_pc", wpc, 64'd0);
            check("clr_busy", 64'(busy), 64'd1);
            check("clr_ready", 64'(uready), 64'd0);
            pop = 1'b0;
        end else begin
            pop = (m_q.size() > 0) && !rq;
            check("run_busy", 64'(busy), 64'd0);
            check("run_valid", 64'(wv), 64'(pop));
            check("run_ready", 64'(uready), 64'(m_q.size() < 4 || pop));
            if (pop) begin
                check("upd_clear", 64'(wclr), 64'd0);
                check("upd_pc", wpc, m_q[0][63:0]);
                check("upd_index", 64'(widx), 64'((m_q[0][63:0] >> 1) % 256));
                check("upd_taken", 64'(wtk), 64'(m_q[0][64]));
            end
        end
        check("drop_cnt", 64'(dcnt), 64'(m_drop));
        if (r) begin
            m_clearing = 1; m_sweep = 0; m_q.delete(); m_drop = 0;
        end else begin
            if (m_clearing) begin
                m_sweep++;
                if (m_sweep == 256) begin
                    m_clearing = 0;
                    m_sweep = 0;
                end
            end else begin
                if (pop) void'(m_q.pop_front());
                if (v && !d && !f) begin
                    if (m_q.size() < 4) m_q.push_back({tk, pc});
                    else if (m_drop < 65535) m_drop++;
                end
            end
            if (f) begin
                m_clearing = 1; m_sweep = 0; m_q.delete();
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit rq);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 64'd0, 0, rq);
    endtask

    task automatic upd(input logic [63:0] pc, input bit tk, input bit rq);
        step(0, 0, 0, 1, pc, tk, rq);
    endtask

    initial begin
        logic [63:0] rpc;
        rst = 1; flush = 0; dbg = 0; uv = 0; upc = '0; utk = 0; rd = 0;
        m_clearing = 1; m_sweep = 0; m_drop = 0;
        @(posedge clk);
        step(1, 0, 0, 0, 64'd0, 0, 0);
        step(1, 0, 0, 0, 64'd0, 0, 0);
        // full sweep after reset, then RUN
        idle(256, 0);
        idle(1, 0);

        // single update appears one cycle later at index 0x08
        upd(64'h8000_0010, 1, 0);
        #1;
        check("lat_index", 64'(widx), 64'h08);
        check("lat_valid", 64'(wv), 64'd1);
        idle(1, 0);

        // rd_req held: four accepted, two dropped
        for (int i = 0; i < 6; i++) upd(64'h1000 + 64'(i * 4), i[0], 1);
        idle(1, 1);
        check("drop_two", 64'(dcnt), 64'd2);
        check("full_ready", 64'(uready), 64'd0);
        idle(5, 0);

        // full FIFO accepts while the head pops
        for (int i = 0; i < 4; i++) upd(64'h2000 + 64'(i * 2), 1, 1);
        upd(64'h3002, 0, 0);
        check("no_new_drop", 64'(dcnt), 64'd2);
        idle(6, 0);

        // flush with two queued updates, flush again at sweep index 100
        upd(64'h4000, 1, 1);
        upd(64'h4002, 0, 1);
        step(0, 1, 0, 0, 64'd0, 0, 1);
        idle(100, 0);
        step(0, 1, 0, 0, 64'd0, 0, 0);
        idle(256, 0);
        idle(2, 0);

        // debug mode and flush-concurrent updates are ignored
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 64'h5000, 1, 0);
        step(0, 1, 0, 1, 64'h6000, 1, 0);
        idle(258, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rpc = {$urandom, $urandom};
            step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                 rpc, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
